// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the PDM-to-PCM CIC decimator.
// Exports CIC_ORDER, PCM_W, cic_width() and pdm_to_signed().
package pdm_pkg;

  localparam int CIC_ORDER = 3;
  localparam int PCM_W = 16;

  function automatic int cic_width(input int decim);
    return 2 + CIC_ORDER * $clog2(decim);
  endfunction

  function automatic logic signed [1:0] pdm_to_signed(
    input logic b
  );
    return b ? 2'sb01 : 2'sb11;
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// One enabled, wrapping accumulator stage of the CIC integrator chain.
// Ports: clk, rst (async active-low), en, din[W-1:0], acc[W-1:0].
module cic_integrator #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + din;
    end
  end

endmodule

// File: rtl/pdm_cic_decim.sv
// 3rd-order CIC decimator turning a 1-bit PDM stream into 16-bit PCM.
// Ports: clk, rst (async active-low), pdm_din, din_valid,
// pcm_dout[15:0], pcm_valid. Macro PCM_SAT_EN clips before slicing.
module pdm_cic_decim
  import pdm_pkg::*;
#(
  parameter int DECIM = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pdm_din,
  input  logic             din_valid,
  output logic [PCM_W-1:0] pcm_dout,
  output logic             pcm_valid
);

  localparam int W = cic_width(DECIM);
  localparam int CW = $clog2(DECIM);
  localparam int SH = W - PCM_W - 1;
  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

  logic signed [1:0] step;
  logic [W-1:0] x;
  logic [W-1:0] i1;
  logic [W-1:0] i2;
  logic [W-1:0] i3;

  assign step = pdm_to_signed(pdm_din);
  assign x = {{(W-1){step[1]}}, step[0]};

  cic_integrator #(.W(W)) u_int1 (
    .clk (clk),
    .rst (rst),
    .en  (din_valid),
    .din (x),
    .acc (i1)
  );

  cic_integrator #(.W(W)) u_int2 (
    .clk (clk),
    .rst (rst),
    .en  (din_valid),
    .din (i1),
    .acc (i2)
  );

  cic_integrator #(.W(W)) u_int3 (
    .clk (clk),
    .rst (rst),
    .en  (din_valid),
    .din (i2),
    .acc (i3)
  );

  logic [CW-1:0] cnt;
  logic frame_end;

  assign frame_end = din_valid && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (din_valid) begin
      cnt <= frame_end ? '0 : cnt + CW'(1);
    end
  end

  // Decimation point: capture the last integrator once per frame.
  logic dec_stb;
  logic [W-1:0] dec_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_stb <= 1'b0;
      dec_val <= '0;
    end else begin
      dec_stb <= frame_end;
      if (frame_end) begin
        dec_val <= i3;
      end
    end
  end

  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] d3;
  logic [W-1:0] c1;
  logic [W-1:0] c2;
  logic [PCM_W-1:0] pcm_next;

`ifdef PCM_SAT_EN
  // Top bit plus the slice; the top two bits disagree on overflow.
  logic [PCM_W:0] top;

  always_comb begin
    c1 = dec_val - d1;
    c2 = c1 - d2;
    top = (PCM_W+1)'((c2 - d3) >> SH);
    pcm_next = top[PCM_W-1:0];
    if (top[PCM_W] != top[PCM_W-1]) begin
      pcm_next = top[PCM_W] ? {1'b1, {(PCM_W-1){1'b0}}}
                            : {1'b0, {(PCM_W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    c1 = dec_val - d1;
    c2 = c1 - d2;
    pcm_next = PCM_W'((c2 - d3) >> SH);
  end
`endif

  logic [PCM_W-1:0] comb_pcm;
  logic comb_stb;
  logic [1:0] warm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
      comb_pcm <= '0;
      comb_stb <= 1'b0;
      warm <= 2'd0;
    end else begin
      comb_stb <= 1'b0;
      if (dec_stb) begin
        d1 <= dec_val;
        d2 <= c1;
        d3 <= c2;
        comb_pcm <= pcm_next;
        // First three frames only prime the comb delays.
        if (warm == 2'd3) begin
          comb_stb <= 1'b1;
        end else begin
          warm <= warm + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcm_dout <= '0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= comb_stb;
      if (comb_stb) begin
        pcm_dout <= comb_pcm;
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Directed bench for pdm_cic_decim at DECIM=64 and DECIM=32.
// Checks latency, period, values, hold and async reset.
module tb_pdm_cic_decim;

`ifdef PCM_SAT_EN
  localparam logic [15:0] FULL = 16'h7FFF;
`else
  localparam logic [15:0] FULL = 16'h8000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pdm_din = 1'b0;
  logic din_valid = 1'b0;
  logic [15:0] dout64;
  logic [15:0] dout32;
  logic val64;
  logic val32;

  int errors = 0;
  int checks = 0;

  pdm_cic_decim #(.DECIM(64)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .pdm_din   (pdm_din),
    .din_valid (din_valid),
    .pcm_dout  (dout64),
    .pcm_valid (val64)
  );

  pdm_cic_decim #(.DECIM(32)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .pdm_din   (pdm_din),
    .din_valid (din_valid),
    .pcm_dout  (dout32),
    .pcm_valid (val32)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    string name;
    int pat;
    int stride;
    logic [15:0] v64;
    logic [15:0] v32;
    int f64;
    int p64;
    int f32;
    int p32;
    int edges;
  } vec_t;

  vec_t vecs[4];

  int pat_cur;
  int stride_cur;
  int k;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input int t);
    din_valid = ((t - 1) % stride_cur) == 0;
    if (din_valid) begin
      k++;
    end
    case (pat_cur)
      0: pdm_din = 1'b1;
      1: pdm_din = 1'b0;
      default: pdm_din = (k % 2) == 1;
    endcase
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    rst = 1'b0;
    din_valid = 1'b0;
    pdm_din = 1'b0;
    #1;
    chk({nm, " rst dout64"}, 32'(dout64), 32'h0);
    chk({nm, " rst valid"}, 32'({val64, val32}), 32'h0);
    chk({nm, " rst dout32"}, 32'(dout32), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    k = 0;
    set_in(1);
  endtask

  task automatic run_row(input vec_t v);
    int e64[$];
    int e32[$];
    logic [15:0] q64[$];
    logic [15:0] q32[$];
    logic [15:0] prev64;
    logic [15:0] prev32;
    int hold64;
    int hold32;
    pat_cur = v.pat;
    stride_cur = v.stride;
    do_reset(v.name);
    prev64 = dout64;
    prev32 = dout32;
    hold64 = 0;
    hold32 = 0;
    for (int t = 1; t <= v.edges; t++) begin
      @(posedge clk);
      #1;
      if (val64) begin
        e64.push_back(t);
        q64.push_back(dout64);
      end else if (dout64 !== prev64) begin
        hold64++;
      end
      if (val32) begin
        e32.push_back(t);
        q32.push_back(dout32);
      end else if (dout32 !== prev32) begin
        hold32++;
      end
      prev64 = dout64;
      prev32 = dout32;
      set_in(t + 1);
    end
    chk({v.name, " n64"}, 32'(e64.size()), 32'd3);
    chk({v.name, " n32"}, 32'(e32.size() >= 3), 32'd1);
    chk({v.name, " hold64"}, 32'(hold64), 32'd0);
    chk({v.name, " hold32"}, 32'(hold32), 32'd0);
    if (e64.size() >= 3) begin
      chk({v.name, " first64"}, 32'(e64[0]), 32'(v.f64));
      chk({v.name, " per64a"}, 32'(e64[1] - e64[0]), 32'(v.p64));
      chk({v.name, " per64b"}, 32'(e64[2] - e64[1]), 32'(v.p64));
      for (int i = 0; i < 3; i++) begin
        chk({v.name, " val64"}, 32'(q64[i]), 32'(v.v64));
      end
    end
    if (e32.size() >= 3) begin
      chk({v.name, " first32"}, 32'(e32[0]), 32'(v.f32));
      chk({v.name, " per32"}, 32'(e32[2] - e32[1]), 32'(v.p32));
      chk({v.name, " val32"}, 32'(q32[2]), 32'(v.v32));
    end
  endtask

  task automatic mid_reset();
    int first;
    logic [15:0] fv;
    pat_cur = 0;
    stride_cur = 1;
    do_reset("midrst");
    for (int t = 1; t <= 286; t++) begin
      @(posedge clk);
      #1;
      set_in(t + 1);
    end
    chk("midrst pre dout", 32'(dout64), 32'(FULL));
    rst = 1'b0;
    #1;
    chk("midrst dout64", 32'(dout64), 32'h0);
    chk("midrst valid64", 32'(val64), 32'h0);
    @(posedge clk);
    #1;
    chk("midrst held", 32'({val64, dout64}), 32'h0);
    rst = 1'b1;
    k = 0;
    set_in(1);
    first = 0;
    fv = '0;
    for (int t = 1; t <= 300; t++) begin
      @(posedge clk);
      #1;
      if (val64 && first == 0) begin
        first = t;
        fv = dout64;
      end
      set_in(t + 1);
    end
    chk("midrst first", 32'(first), 32'd258);
    chk("midrst value", 32'(fv), 32'(FULL));
  endtask

  initial begin
    vecs[0] = '{"all1", 0, 1, FULL, FULL, 258, 64, 130, 32, 400};
    vecs[1] = '{"all0", 1, 1, 16'h8000, 16'h8000,
                258, 64, 130, 32, 400};
    vecs[2] = '{"alt", 2, 1, 16'h0000, 16'h0000,
                258, 64, 130, 32, 400};
    vecs[3] = '{"stall4", 0, 4, FULL, FULL,
                1023, 256, 511, 128, 1560};
    #2;
    for (int r = 0; r < 4; r++) begin
      run_row(vecs[r]);
    end
    mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pdm_cic_decim.md
PDM_CIC_DECIM -- requirements
Module: pdm_cic_decim

Interface
REQ-001 SHALL have parameter DECIM, default 64, meaning decimation ratio; legal values are powers of two from 32 to 256.
REQ-002 SHALL have port clk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port pdm_din, input, 1 bit: PDM bit from the modulator or microphone.
REQ-005 SHALL have port din_valid, input, 1 bit: pdm_din is sampled on edges where din_valid=1.
REQ-006 SHALL have port pcm_dout, output, 16 bits: signed two's-complement PCM sample.
REQ-007 SHALL have port pcm_valid, output, 1 bit: one-clock pulse when pcm_dout updates.

Function
REQ-008 SHALL map an accepted pdm_din of 1 to +1 and of 0 to -1.
REQ-009 SHALL implement a 3rd-order CIC filter with the following stages:
- three integrators at the input rate, updating only when din_valid=1;
- a decimation strobe every DECIM accepted samples;
- three combs with differential delay 1 at the output rate.
REQ-010 SHALL use internal width W = 2 + 3*log2(DECIM) (20 for DECIM=64); integrator and comb arithmetic wraps modulo 2^W.
REQ-011 SHALL use a sample counter 0..DECIM-1 that:
- increments on each accepted sample;
- wraps from DECIM-1 to 0;
- asserts the decimation strobe on the accepted sample where the count is DECIM-1.
REQ-012 SHALL register the comb chain result, so pcm_valid rises exactly 2 clk edges after the edge that accepted the frame-completing sample.
REQ-013 SHALL form pcm_dout from comb result bits [W-2 -: 16]; with DECIM=64 these are bits [18:3].
REQ-014 SHALL hold pcm_dout stable between pcm_valid pulses.
REQ-015 SHALL treat din_valid=0 as a stall: no counter, integrator or comb state changes.
REQ-016 SHALL accept din_valid high every cycle; in that case pcm_valid has period exactly DECIM clocks.
REQ-017 SHALL use a warm-up counter 0..3 that suppresses pcm_valid for the first 3 decimated outputs after reset; the first pcm_valid is the 4th frame.
REQ-018 SHALL leave pcm_dout unchanged (0x0000) during warm-up.

Reset
REQ-019 SHALL, while rst=0, asynchronously clear the following to 0, regardless of din_valid:
- all integrators, comb delays and output registers;
- the sample counter and the warm-up counter;
- pcm_dout (0x0000) and pcm_valid.
REQ-020 SHALL discard any partial frame when rst is asserted mid-frame; counting restarts at 0 and warm-up restarts at 0.
REQ-021 SHALL accept the first sample on the first clk edge after rst deasserts.

Configuration
REQ-022 SHALL support macro PCM_SAT_EN:
- when defined, the W-bit comb result is clipped to [-2^(W-2), 2^(W-2)-1] before slicing, so full-scale positive input gives 0x7FFF;
- when undefined, the slice is taken without clipping, so full-scale positive wraps to 0x8000.

Structure
REQ-023 SHALL place the following in shared package pdm_pkg:
- CIC_ORDER = 3;
- PCM_W = 16;
- a W-from-DECIM width function;
- the PDM-bit-to-signed mapping.
REQ-024 SHALL use sub-module cic_integrator (parameter W; one enabled wrapping accumulator), instantiated 3 times; combs are inline.

Verification
REQ-025 SHALL cover these directed scenarios (DECIM=64, din_valid=1 every cycle unless stated):
- pdm_din all 1s → pcm_valid period 64, first pulse at frame 4 (edge 4*64+2 after reset release); steady pcm_dout 0x7FFF with PCM_SAT_EN, 0x8000 without.
- pdm_din all 0s → steady pcm_dout 0x8000 in both builds.
- pdm_din alternating 1,0 → steady pcm_dout 0x0000 from the 4th valid output onward.
- pdm_din all 1s with din_valid high 1 cycle in 4 → pcm_valid period 256 clocks, same values as the first scenario.
- rst pulsed low for 1 cycle at sample 30 of frame 5 → pcm_dout 0x0000 and pcm_valid 0 immediately; next pcm_valid at frame 4 counted from release.
- DECIM=32, all 1s with PCM_SAT_EN → W=17, pcm_dout 0x7FFF every 32 clocks after warm-up.
